// File: rtl/led_pkg.sv
// Shared types and helpers for the scrolling seven-segment driver:
// active-low hex decode, blank pattern and the debounce state encoding.
package led_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HIGH,
    HELD,
    WAIT_LOW
  } deb_state_e;

  // Segment order is a..g from bit 6 down to bit 0; a lit segment is 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus a four-state debounce FSM; emits one press
// pulse per accepted rising edge of the button, however long it is held.
module button_debouncer
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_done;

  assign cnt_done = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The pulse is decoded from registered state so it lands in the cycle
  // before the WAIT_HIGH -> HELD edge.
  always_comb begin
    // NOTE: defaults first keep every branch fully assigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = HELD;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/scrolling_led_driver.sv
// Multiplexed seven-segment driver showing a DIGITS-wide window onto a
// MSG_LEN-nibble message, scrolled by button presses or an auto timer.
module scrolling_led_driver
  import led_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int MSG_LEN         = 16,
  parameter int REFRESH_DIV     = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int AUTO_PERIOD     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       button,
  input  logic                       auto_en,
  input  logic [4*MSG_LEN-1:0]       msg,
  output logic [DIGITS-1:0]          an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [$clog2(MSG_LEN)-1:0] pos
);

  localparam int PW = $clog2(MSG_LEN);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int AW = $clog2(AUTO_PERIOD);

  logic [SW-1:0]     slot_q, slot_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [AW-1:0]     auto_q, auto_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic          press, tick, step, slot_wrap;
  logic [PW:0]   k_sum, k_mod;
  logic [PW-1:0] k;
  logic [3:0]    nibble;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst_n (reset),
    .button(button),
    .press (press)
  );

  assign slot_wrap = (slot_q == SW'(REFRESH_DIV - 1));
  assign tick      = auto_en && (auto_q == AW'(AUTO_PERIOD - 1));
  assign step      = press | tick;

  // One extra bit holds pos + offset before folding back into 0..MSG_LEN-1.
  assign k_sum  = {1'b0, pos_q} + (PW+1)'(DIGITS - 1) - (PW+1)'(digit_q);
  assign k_mod  = (k_sum >= (PW+1)'(MSG_LEN)) ? k_sum - (PW+1)'(MSG_LEN) : k_sum;
  assign k      = k_mod[PW-1:0];
  assign nibble = msg[{k, 2'b00} +: 4];

  always_comb begin
    slot_d  = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d = digit_q;
    if (slot_wrap) begin
      digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end

    auto_d = '0;
    if (auto_en && !tick) begin
      auto_d = auto_q + 1'b1;
    end

    pos_d = pos_q;
    if (step) begin
      pos_d = (pos_q == PW'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
    end

    // Anodes go dark for the first cycle of every slot to hide switching ghosts.
    an_d = slot_wrap ? '1 : ~(DIGITS'(1) << digit_q);

    // Content is latched once per slot, so a pos change shows from the next slot.
    seg_d = seg_q;
    dp_d  = dp_q;
    if (slot_q == '0) begin
      seg_d = hex_to_seg(nibble);
      dp_d  = (k != PW'(MSG_LEN - 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q  <= '0;
      digit_q <= '0;
      auto_q  <= '0;
      pos_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
      auto_q  <= auto_d;
      pos_q   <= pos_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign pos = pos_q;

endmodule

// File: tb/tb_scrolling_led_driver.sv
// Directed bench for scrolling_led_driver with a fast refresh (REFRESH_DIV=4).
module tb_scrolling_led_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        button;
  logic        auto_en;
  logic [63:0] msg;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  pos;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t       vecs[16];
  logic [3:0] exp_an[4];
  logic [6:0] exp_seg13[4];
  logic       exp_dp13[4];

  scrolling_led_driver #(
    .DIGITS         (4),
    .MSG_LEN        (16),
    .REFRESH_DIV    (4),
    .DEBOUNCE_CYCLES(8),
    .AUTO_PERIOD    (64)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .button (button),
    .auto_en(auto_en),
    .msg    (msg),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .pos    (pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_once();
    button = 1'b1;
    cyc(12);
    button = 1'b0;
    cyc(14);
  endtask

  initial begin
    int blanks;
    int d;

    // Digit-by-digit view right after reset release, pos=0.
    vecs[0]  = '{4'b1110, 7'h06, 1'b1};
    vecs[1]  = '{4'b1110, 7'h06, 1'b1};
    vecs[2]  = '{4'b1110, 7'h06, 1'b1};
    vecs[3]  = '{4'b1111, 7'h06, 1'b1};
    vecs[4]  = '{4'b1101, 7'h12, 1'b1};
    vecs[5]  = '{4'b1101, 7'h12, 1'b1};
    vecs[6]  = '{4'b1101, 7'h12, 1'b1};
    vecs[7]  = '{4'b1111, 7'h12, 1'b1};
    vecs[8]  = '{4'b1011, 7'h4F, 1'b1};
    vecs[9]  = '{4'b1011, 7'h4F, 1'b1};
    vecs[10] = '{4'b1011, 7'h4F, 1'b1};
    vecs[11] = '{4'b1111, 7'h4F, 1'b1};
    vecs[12] = '{4'b0111, 7'h01, 1'b1};
    vecs[13] = '{4'b0111, 7'h01, 1'b1};
    vecs[14] = '{4'b0111, 7'h01, 1'b1};
    vecs[15] = '{4'b1111, 7'h01, 1'b1};

    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    // pos=13: digit 3..0 show D, E, F, 0; only the F digit carries the marker.
    exp_seg13[3] = 7'h42; exp_seg13[2] = 7'h30; exp_seg13[1] = 7'h38; exp_seg13[0] = 7'h01;
    exp_dp13[3]  = 1'b1;  exp_dp13[2]  = 1'b1;  exp_dp13[1]  = 1'b0;  exp_dp13[0]  = 1'b1;

    reset   = 1'b0;
    button  = 1'b0;
    auto_en = 1'b0;
    msg     = 64'hFEDCBA9876543210;

    cyc(3);
    check("reset_an",  32'(an),  32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp",  32'(dp),  32'h1);
    check("reset_pos", 32'(pos), 32'h0);

    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      check($sformatf("refresh_vec%0d", i), 32'({an, seg, dp}),
            32'({vecs[i].an, vecs[i].seg, vecs[i].dp}));
    end

    // Short bounce: no press.
    button = 1'b1;
    cyc(5);
    button = 1'b0;
    cyc(500);
    check("bounce_pos", 32'(pos), 32'h0);

    // Long hold: exactly one step, 11 edges after the rising edge.
    button = 1'b1;
    cyc(10);
    check("hold_pos_early", 32'(pos), 32'h0);
    cyc(1);
    check("hold_pos_step", 32'(pos), 32'h1);
    cyc(189);
    check("hold_pos_long", 32'(pos), 32'h1);
    button = 1'b0;
    cyc(20);
    button = 1'b1;
    cyc(15);
    button = 1'b0;
    cyc(20);
    check("second_press_pos", 32'(pos), 32'h2);

    for (int i = 0; i < 11; i++) press_once();
    check("pos13", 32'(pos), 32'd13);

    cyc(8);
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (an == 4'b1111) begin
        blanks++;
      end else begin
        d = -1;
        for (int j = 0; j < 4; j++) if (an == exp_an[j]) d = j;
        if (d < 0) begin
          n_checks++;
          $display("FAIL sweep_an: got %b, required a single active anode", an);
        end else begin
          check($sformatf("sweep_seg_d%0d", d), 32'(seg), 32'(exp_seg13[d]));
          check($sformatf("sweep_dp_d%0d", d),  32'(dp),  32'(exp_dp13[d]));
        end
      end
    end
    check("sweep_blank_slots", 32'(blanks), 32'd4);

    for (int i = 0; i < 3; i++) press_once();
    check("pos_wrap", 32'(pos), 32'h0);

    // Auto scroll.
    auto_en = 1'b1;
    cyc(63);
    check("auto_before_tick", 32'(pos), 32'h0);
    cyc(1);
    check("auto_tick1", 32'(pos), 32'h1);
    cyc(64);
    check("auto_tick2", 32'(pos), 32'h2);
    cyc(53);
    button = 1'b1;  // press pulse lands on the third tick cycle
    cyc(10);
    check("coincide_before", 32'(pos), 32'h2);
    cyc(1);
    check("coincide_single_step", 32'(pos), 32'h3);
    button  = 1'b0;
    auto_en = 1'b0;
    cyc(200);
    check("auto_off_frozen", 32'(pos), 32'h3);

    // Reset mid-operation with the FSM in WAIT_HIGH.
    press_once();
    press_once();
    check("pre_reset_pos", 32'(pos), 32'h5);
    button = 1'b1;
    cyc(5);
    reset = 1'b0;
    #1;
    check("midreset_an",  32'(an),  32'hF);
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_dp",  32'(dp),  32'h1);
    check("midreset_pos", 32'(pos), 32'h0);
    cyc(3);
    reset = 1'b1;
    cyc(10);
    check("rerelease_pos_early", 32'(pos), 32'h0);
    cyc(1);
    check("rerelease_pos_step", 32'(pos), 32'h1);
    button = 1'b0;
    cyc(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
